// File: rtl/shop_pkg.sv
// Shared widths, command keys, response strings and the command decoder
// for the shop command controller.
package shop_pkg;

  localparam int I_A_NUM_ASCII_CHARS = 7;
  localparam int O_A_NUM_ASCII_CHARS = 9;
  localparam int I_A_NUM_BITS        = I_A_NUM_ASCII_CHARS * 8;
  localparam int I_U_NUM_BITS        = 4;
  localparam int O_A_NUM_BITS        = O_A_NUM_ASCII_CHARS * 8;
  localparam int MAX_USERS           = 5;
  localparam int MAX_ITEMS           = 15;
  localparam int RESP_HOLD           = 2;
  localparam int STOCK_BITS          = $clog2(MAX_ITEMS + 1);
  localparam int HOLD_BITS           = $clog2(RESP_HOLD + 1);

  typedef logic [I_A_NUM_BITS-1:0] key_t;
  typedef logic [O_A_NUM_BITS-1:0] resp_t;
  typedef logic [I_U_NUM_BITS-1:0] uid_t;
  typedef logic [STOCK_BITS-1:0]   stock_t;
  typedef logic [HOLD_BITS-1:0]    hold_t;

  // Keys and responses are right-justified and zero-padded on the left.
  localparam key_t CMD_KEY__LOGOUT      = key_t'("Logout");
  localparam key_t CMD_KEY__LOGIN       = key_t'("Login");
  localparam key_t CMD_KEY__ADD_USER    = key_t'("AddUsr");
  localparam key_t CMD_KEY__DELETE_USER = key_t'("DelUsr");
  localparam key_t CMD_KEY__ADD_ITEM    = key_t'("AddItem");
  localparam key_t CMD_KEY__DELETE_ITEM = key_t'("DelItem");
  localparam key_t CMD_KEY__BUY         = key_t'("Buy");
  localparam key_t CMD_KEY__NONE        = key_t'("NONE");

  localparam resp_t RESP_PROMPT     = resp_t'("Cmd?");
  localparam resp_t RESP_INVAL_CMD  = resp_t'("InvalCmd");
  localparam resp_t RESP_INVAL_PERM = resp_t'("InvalPerm");
  localparam resp_t RESP_LOGGED_IN  = resp_t'("LoggedIn");
  localparam resp_t RESP_LOGGED_OUT = resp_t'("LoggedOut");
  localparam resp_t RESP_NO_USR     = resp_t'("NoUsr");
  localparam resp_t RESP_USR_EXISTS = resp_t'("UsrExists");
  localparam resp_t RESP_DONE       = resp_t'("Done");
  localparam resp_t RESP_FULL       = resp_t'("Full");
  localparam resp_t RESP_NO_STOCK   = resp_t'("NoStock");

  localparam stock_t STOCK_MAX = stock_t'(MAX_ITEMS);
  localparam hold_t  HOLD_INIT = hold_t'(RESP_HOLD);

  typedef enum logic [3:0] {
    CMD_INVALID,
    CMD_NONE,
    CMD_LOGOUT,
    CMD_LOGIN,
    CMD_ADD_USER,
    CMD_DEL_USER,
    CMD_ADD_ITEM,
    CMD_DEL_ITEM,
    CMD_BUY
  } cmd_e;

  function automatic cmd_e decode_cmd(input key_t key);
    case (key)
      CMD_KEY__LOGOUT:      return CMD_LOGOUT;
      CMD_KEY__LOGIN:       return CMD_LOGIN;
      CMD_KEY__ADD_USER:    return CMD_ADD_USER;
      CMD_KEY__DELETE_USER: return CMD_DEL_USER;
      CMD_KEY__ADD_ITEM:    return CMD_ADD_ITEM;
      CMD_KEY__DELETE_ITEM: return CMD_DEL_ITEM;
      CMD_KEY__BUY:         return CMD_BUY;
      CMD_KEY__NONE:        return CMD_NONE;
      default:              return CMD_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/shop_user_table.sv
// User slot table: one valid bit per user id, slot 0 (admin) pinned valid.
module shop_user_table
  import shop_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_add,
  input  logic                    i_del,
  input  logic [I_U_NUM_BITS-1:0] i_id,
  output logic                    o_valid,
  output logic                    o_in_range
);

  logic [MAX_USERS-1:0] r_valid;

  assign o_in_range = (i_id < uid_t'(MAX_USERS));

  // NOTE: every always_comb output gets a default before any branch so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    o_valid = 1'b0;
    for (int i = 0; i < MAX_USERS; i++) begin
      if (i_id == uid_t'(i)) o_valid = r_valid[i];
    end
  end

  // The table is a handful of flops, so it is reset like any other state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= MAX_USERS'(1);
    end else begin
      r_valid[0] <= 1'b1;
      for (int i = 1; i < MAX_USERS; i++) begin
        if (i_add && i_id == uid_t'(i)) r_valid[i] <= 1'b1;
        else if (i_del && i_id == uid_t'(i)) r_valid[i] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/shop.sv
// Shop command controller: edge-detects i_rdy, decodes the ASCII command,
// applies login/permission rules and drives a held ASCII response on o_a.
module shop
  import shop_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_rdy,
  input  logic [I_U_NUM_BITS-1:0] i_u,
  input  logic [I_A_NUM_BITS-1:0] i_a,
  output logic [O_A_NUM_BITS-1:0] o_a
);

  logic   r_rdy_prev;
  logic   r_logged_in;
  uid_t   r_cur_user;
  stock_t r_stock;
  hold_t  r_hold;
  resp_t  r_o_a;

  logic  w_accept;
  cmd_e  w_cmd;
  logic  w_is_admin;
  logic  w_usr_valid;
  logic  w_usr_in_range;
  resp_t w_resp;
  logic  w_resp_en;
  logic  w_login;
  logic  w_logout;
  logic  w_usr_add;
  logic  w_usr_del;
  logic  w_stock_inc;
  logic  w_stock_dec;

  assign w_accept   = i_rdy && !r_rdy_prev;
  assign w_cmd      = decode_cmd(i_a);
  assign w_is_admin = r_logged_in && (r_cur_user == '0);
  assign o_a        = r_o_a;

  shop_user_table u_user_table (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_add      (w_accept && w_usr_add),
    .i_del      (w_accept && w_usr_del),
    .i_id       (i_u),
    .o_valid    (w_usr_valid),
    .o_in_range (w_usr_in_range)
  );

  // Unknown keys are rejected before any login check; NONE never produces
  // a response so the prompt (or a running hold) is left untouched.
  always_comb begin
    w_resp      = RESP_INVAL_CMD;
    w_resp_en   = 1'b1;
    w_login     = 1'b0;
    w_logout    = 1'b0;
    w_usr_add   = 1'b0;
    w_usr_del   = 1'b0;
    w_stock_inc = 1'b0;
    w_stock_dec = 1'b0;
    case (w_cmd)
      CMD_NONE: w_resp_en = 1'b0;
      CMD_LOGIN: begin
        if (r_logged_in) w_resp = RESP_INVAL_PERM;
        else if (!w_usr_in_range || !w_usr_valid) w_resp = RESP_NO_USR;
        else begin
          w_resp  = RESP_LOGGED_IN;
          w_login = 1'b1;
        end
      end
      CMD_LOGOUT: begin
        if (!r_logged_in) w_resp = RESP_INVAL_PERM;
        else begin
          w_resp   = RESP_LOGGED_OUT;
          w_logout = 1'b1;
        end
      end
      CMD_ADD_USER: begin
        if (!w_is_admin) w_resp = RESP_INVAL_PERM;
        else if (i_u == '0 || !w_usr_in_range) w_resp = RESP_NO_USR;
        else if (w_usr_valid) w_resp = RESP_USR_EXISTS;
        else begin
          w_resp    = RESP_DONE;
          w_usr_add = 1'b1;
        end
      end
      CMD_DEL_USER: begin
        if (!w_is_admin || i_u == '0) w_resp = RESP_INVAL_PERM;
        else if (!w_usr_in_range || !w_usr_valid) w_resp = RESP_NO_USR;
        else begin
          w_resp    = RESP_DONE;
          w_usr_del = 1'b1;
        end
      end
      CMD_ADD_ITEM: begin
        if (!w_is_admin) w_resp = RESP_INVAL_PERM;
        else if (r_stock == STOCK_MAX) w_resp = RESP_FULL;
        else begin
          w_resp      = RESP_DONE;
          w_stock_inc = 1'b1;
        end
      end
      CMD_DEL_ITEM, CMD_BUY: begin
        if ((w_cmd == CMD_DEL_ITEM) ? !w_is_admin : (!r_logged_in || w_is_admin))
          w_resp = RESP_INVAL_PERM;
        else if (r_stock == '0) w_resp = RESP_NO_STOCK;
        else begin
          w_resp      = RESP_DONE;
          w_stock_dec = 1'b1;
        end
      end
      default: w_resp = RESP_INVAL_CMD;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop in
  // this block samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdy_prev  <= 1'b0;
      r_logged_in <= 1'b0;
      r_cur_user  <= '0;
      r_stock     <= '0;
      r_hold      <= '0;
      r_o_a       <= RESP_PROMPT;
    end else begin
      r_rdy_prev <= i_rdy;

      if (w_accept && w_resp_en) begin
        r_o_a  <= w_resp;
        r_hold <= HOLD_INIT;
      end else if (r_hold != '0) begin
        r_hold <= r_hold - hold_t'(1);
        if (r_hold == hold_t'(1)) r_o_a <= RESP_PROMPT;
      end

      if (w_accept) begin
        if (w_login) begin
          r_logged_in <= 1'b1;
          r_cur_user  <= i_u;
        end
        if (w_logout)    r_logged_in <= 1'b0;
        if (w_stock_inc) r_stock     <= r_stock + stock_t'(1);
        if (w_stock_dec) r_stock     <= r_stock - stock_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_shop.sv
// Self-checking bench for shop: directed scenarios plus randomized commands
// compared against a string-level reference model of the shop rules.
module tb_shop;
  import shop_pkg::*;

  logic                    i_clk;
  logic                    i_reset;
  logic                    i_rdy;
  logic [I_U_NUM_BITS-1:0] i_u;
  logic [I_A_NUM_BITS-1:0] i_a;
  logic [O_A_NUM_BITS-1:0] o_a;

  int checks   = 0;
  int failures = 0;

  shop dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_rdy   (i_rdy),
    .i_u     (i_u),
    .i_a     (i_a),
    .o_a     (o_a)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  bit m_valid[MAX_USERS];
  bit m_logged;
  int m_cur;
  int m_stock;

  function automatic void model_reset();
    foreach (m_valid[i]) m_valid[i] = (i == 0);
    m_logged = 0;
    m_cur    = 0;
    m_stock  = 0;
  endfunction

  function automatic string model(string key, int u);
    bit admin = m_logged && (m_cur == 0);
    case (key)
      "NONE": return "Cmd?";
      "Login": begin
        if (m_logged) return "InvalPerm";
        if (u >= MAX_USERS) return "NoUsr";
        if (!m_valid[u]) return "NoUsr";
        m_logged = 1; m_cur = u; return "LoggedIn";
      end
      "Logout": begin
        if (!m_logged) return "InvalPerm";
        m_logged = 0; return "LoggedOut";
      end
      "AddUsr": begin
        if (!admin) return "InvalPerm";
        if (u == 0 || u >= MAX_USERS) return "NoUsr";
        if (m_valid[u]) return "UsrExists";
        m_valid[u] = 1; return "Done";
      end
      "DelUsr": begin
        if (!admin || u == 0) return "InvalPerm";
        if (u >= MAX_USERS) return "NoUsr";
        if (!m_valid[u]) return "NoUsr";
        m_valid[u] = 0; return "Done";
      end
      "AddItem": begin
        if (!admin) return "InvalPerm";
        if (m_stock >= MAX_ITEMS) return "Full";
        m_stock++; return "Done";
      end
      "DelItem": begin
        if (!admin) return "InvalPerm";
        if (m_stock == 0) return "NoStock";
        m_stock--; return "Done";
      end
      "Buy": begin
        if (!m_logged || admin) return "InvalPerm";
        if (m_stock == 0) return "NoStock";
        m_stock--; return "Done";
      end
      default: return "InvalCmd";
    endcase
  endfunction

  function automatic logic [I_A_NUM_BITS-1:0] enc_key(string s);
    logic [I_A_NUM_BITS-1:0] v = '0;
    for (int i = 0; i < s.len(); i++) v = {v[I_A_NUM_BITS-9:0], s[i]};
    return v;
  endfunction

  function automatic logic [O_A_NUM_BITS-1:0] enc_resp(string s);
    logic [O_A_NUM_BITS-1:0] v = '0;
    for (int i = 0; i < s.len(); i++) v = {v[O_A_NUM_BITS-9:0], s[i]};
    return v;
  endfunction

  // ---------------- drivers (called at a negedge, return at a negedge) ----
  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_rdy = 1'b0; i_u = 'x; i_a = '0;
    @(negedge i_clk);
    i_reset = 1'b0;
    model_reset();
  endtask

  // One-cycle i_rdy pulse; got is o_a in the first cycle after the accept edge.
  task automatic send(input string key, input int u, output logic [O_A_NUM_BITS-1:0] got);
    i_a = enc_key(key);
    if (key == "Login" || key == "AddUsr" || key == "DelUsr") i_u = u[I_U_NUM_BITS-1:0];
    else i_u = 'x;
    i_rdy = 1'b1;
    @(negedge i_clk);
    got   = o_a;
    i_rdy = 1'b0;
    i_u   = 'x;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [O_A_NUM_BITS-1:0] got;
    do_reset();
    checks++;
    if (o_a !== enc_resp("Cmd?")) begin
      failures++; $display("FAIL reset_prompt got=%s want=Cmd?", o_a);
    end
    send("Logout", 0, got); idle(1);
    checks++;
    if (got !== enc_resp("InvalPerm")) begin
      failures++; $display("FAIL reset_logged_out got=%s want=InvalPerm", got);
    end
    send("Login", 0, got); idle(1);
    send("DelItem", 0, got); idle(1);
    checks++;
    if (got !== enc_resp("NoStock")) begin
      failures++; $display("FAIL reset_stock_zero got=%s want=NoStock", got);
    end
  endtask

  task automatic test_invalid_cmd();
    string want[3] = '{"InvalCmd", "InvalCmd", "Cmd?"};
    do_reset();
    i_a = enc_key("sdfsdf"); i_u = 'x; i_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      i_rdy = 1'b0;
      checks++;
      if (o_a !== enc_resp(want[c])) begin
        failures++; $display("FAIL invalid_cmd_cycle%0d got=%s want=%s", c, o_a, want[c]);
      end
    end
  endtask

  task automatic test_logged_out_perm();
    logic [O_A_NUM_BITS-1:0] got;
    do_reset();
    send("AddItem", 0, got); idle(1);
    checks++;
    if (got !== enc_resp("InvalPerm")) begin
      failures++; $display("FAIL logged_out_additem got=%s want=InvalPerm", got);
    end
    send("Login", 0, got); idle(1);
    send("DelItem", 0, got); idle(1);
    checks++;
    if (got !== enc_resp("NoStock")) begin
      failures++; $display("FAIL logged_out_stock_unchanged got=%s want=NoStock", got);
    end
  endtask

  task automatic test_sequence();
    string keys[8] = '{"Login", "AddUsr", "AddUsr", "AddItem", "Logout", "Login", "Buy", "Buy"};
    int    us[8]   = '{0, 2, 2, 0, 0, 2, 0, 0};
    string want[8] = '{"LoggedIn", "Done", "UsrExists", "Done", "LoggedOut", "LoggedIn", "Done", "NoStock"};
    logic [O_A_NUM_BITS-1:0] got;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      send(keys[k], us[k], got); idle(1);
      checks++;
      if (got !== enc_resp(want[k])) begin
        failures++; $display("FAIL sequence_%0d_%s got=%s want=%s", k, keys[k], got, want[k]);
      end
    end
  endtask

  task automatic test_user_bounds();
    string keys[9] = '{"Login", "DelUsr", "Login", "AddUsr", "AddUsr", "DelUsr", "Logout", "Login", "Login"};
    int    us[9]   = '{0, 0, 3, 5, 0, 4, 0, 3, 7};
    string want[9] = '{"LoggedIn", "InvalPerm", "InvalPerm", "NoUsr", "NoUsr", "NoUsr", "LoggedOut", "NoUsr", "NoUsr"};
    logic [O_A_NUM_BITS-1:0] got;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      send(keys[k], us[k], got); idle(1);
      checks++;
      if (got !== enc_resp(want[k])) begin
        failures++; $display("FAIL bounds_%0d_%s_u%0d got=%s want=%s", k, keys[k], us[k], got, want[k]);
      end
    end
  endtask

  task automatic test_rdy_held_and_full();
    string want[3] = '{"Done", "Done", "Cmd?"};
    logic [O_A_NUM_BITS-1:0] got;
    do_reset();
    send("Login", 0, got); idle(1);
    i_a = enc_key("AddItem"); i_u = 'x; i_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      checks++;
      if (o_a !== enc_resp(want[c])) begin
        failures++; $display("FAIL rdy_held_cycle%0d got=%s want=%s", c, o_a, want[c]);
      end
    end
    i_rdy = 1'b0; idle(1);
    // one increment so far: 14 more fit, the last two of 16 report Full
    for (int k = 0; k < 16; k++) begin
      send("AddItem", 0, got); idle(1);
      checks++;
      if (got !== enc_resp(k < 14 ? "Done" : "Full")) begin
        failures++; $display("FAIL fill_%0d got=%s want=%s", k, got, k < 14 ? "Done" : "Full");
      end
    end
    // stock must be exactly 15: fifteen removals succeed, the sixteenth does not
    for (int k = 0; k < 16; k++) begin
      send("DelItem", 0, got); idle(1);
      checks++;
      if (got !== enc_resp(k < 15 ? "Done" : "NoStock")) begin
        failures++; $display("FAIL drain_%0d got=%s want=%s", k, got, k < 15 ? "Done" : "NoStock");
      end
    end
  endtask

  task automatic test_reset_priority();
    logic [O_A_NUM_BITS-1:0] got;
    do_reset();
    send("Bogus", 0, got);
    i_reset = 1'b1; @(negedge i_clk); i_reset = 1'b0;
    checks++;
    if (o_a !== enc_resp("Cmd?")) begin
      failures++; $display("FAIL reset_during_hold got=%s want=Cmd?", o_a);
    end
    idle(1);
    // i_rdy high across reset: reset wins on that edge, then the first
    // clean edge accepts because the previous-i_rdy was cleared
    i_a = enc_key("Bogus"); i_rdy = 1'b1; i_reset = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_a !== enc_resp("Cmd?")) begin
      failures++; $display("FAIL reset_beats_accept got=%s want=Cmd?", o_a);
    end
    i_reset = 1'b0;
    @(negedge i_clk);
    i_rdy = 1'b0;
    checks++;
    if (o_a !== enc_resp("InvalCmd")) begin
      failures++; $display("FAIL accept_after_reset got=%s want=InvalCmd", o_a);
    end
    idle(2);
  endtask

  task automatic test_random();
    string pool[10] = '{"Logout", "Login", "AddUsr", "DelUsr", "AddItem",
                        "DelItem", "Buy", "NONE", "Bogus", "AddItem"};
    logic [O_A_NUM_BITS-1:0] got;
    string key, want;
    int u;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      key  = pool[$urandom_range(0, 9)];
      u    = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 7));
      want = model(key, u);
      send(key, u, got);
      checks++;
      if (got !== enc_resp(want)) begin
        failures++; $display("FAIL random_%0d_%s_u%0d got=%s want=%s", n, key, u, got, want);
      end
      idle(2);
      checks++;
      if (o_a !== enc_resp("Cmd?")) begin
        failures++; $display("FAIL random_hold_end_%0d got=%s want=Cmd?", n, o_a);
      end
    end
  endtask

  initial begin
    i_reset = 1'b1; i_rdy = 1'b0; i_u = 'x; i_a = '0;
    @(negedge i_clk);
    test_reset();
    test_invalid_cmd();
    test_logged_out_perm();
    test_sequence();
    test_user_bounds();
    test_rdy_held_and_full();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
